// File: rtl/mips_pkg.sv
// Shared datapath constants and types for the 4-way select/distribute blocks.
package mips_pkg;

  localparam int unsigned NUM_WAYS = 4;
  localparam int unsigned SEL_W    = 2;

  typedef logic [SEL_W-1:0] way_sel_t;

  // Occupancy of a one-entry lane holding register.
  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_t;

endpackage : mips_pkg

// File: rtl/demux_lane.sv
// One output lane of the demux: a single-entry holding register plus its full flag.
module demux_lane
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  lane_state_t      state_q, state_d;
  logic [WIDTH-1:0] buf_q, buf_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= LANE_EMPTY;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  // A load into a full lane only happens when it is draining the same edge,
  // so it simply replaces the buffered word.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    unique case (state_q)
      LANE_EMPTY: begin
        if (load) begin
          state_d = LANE_FULL;
          buf_d   = load_data;
        end
      end
      LANE_FULL: begin
        if (load) begin
          buf_d = load_data;
        end else if (drain_ready) begin
          state_d = LANE_EMPTY;
        end
      end
      default: state_d = LANE_EMPTY;
    endcase
  end

  assign valid = (state_q == LANE_FULL);
  assign data  = buf_q;

endmodule : demux_lane

// File: rtl/demux4way_buf.sv
// Registered 1-to-4 demultiplexer with valid/ready handshake and one holding
// register per lane; lanes drain independently.
module demux4way_buf
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [NUM_WAYS*WIDTH-1:0] out_data,
  output logic [NUM_WAYS-1:0]       out_valid,
  input  logic [NUM_WAYS-1:0]       out_ready
);

  way_sel_t            sel;
  logic                accept;
  logic [NUM_WAYS-1:0] load;

  assign sel = in_sel;

  // The selected lane can take a word if it is empty or is draining this edge.
  assign in_ready = ~out_valid[sel] | out_ready[sel];
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < NUM_WAYS; k++) begin : g_lane
    assign load[k] = accept & (sel == way_sel_t'(k));

    demux_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (load[k]),
      .load_data  (in_data),
      .drain_ready(out_ready[k]),
      .valid      (out_valid[k]),
      .data       (out_data[k*WIDTH +: WIDTH])
    );
  end

endmodule : demux4way_buf

// File: tb/tb_demux4way_buf.sv
// Self-checking bench for demux4way_buf: per-lane queue model plus directed literals.
module tb_demux4way_buf;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [W-1:0]   in_data;
  logic [1:0]     in_sel;
  logic           in_valid;
  logic           in_ready;
  logic [4*W-1:0] out_data;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;

  demux4way_buf #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: each lane is a FIFO of at most one word; head is what the lane shows.
  logic [W-1:0] mq[4][$];
  bit           zero_since_rst[4];
  bit           m_known = 1'b0;
  bit           last_acc;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic model_ready(input logic [1:0] s, input logic [3:0] ordy);
    return (mq[s].size() == 0) || ordy[s];
  endfunction

  // One clock: drive inputs after negedge, compare, then advance the model at posedge.
  task automatic cycle(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                       input logic [3:0] ordy, input logic rn);
    logic rdy;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = ordy;
    reset_n   = rn;
    #1;
    rdy = model_ready(s, ordy);
    if (m_known) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("out_valid[%0d]", k), 128'(out_valid[k]), 128'(mq[k].size() != 0));
        if (mq[k].size() != 0)
          chk($sformatf("lane%0d_data", k), 128'(out_data[k*W +: W]), 128'(mq[k][0]));
        else if (zero_since_rst[k])
          chk($sformatf("lane%0d_zero", k), 128'(out_data[k*W +: W]), 128'(0));
      end
      chk("in_ready", 128'(in_ready), 128'(rdy));
    end
    @(posedge clk);
    last_acc = 1'b0;
    if (!rn) begin
      for (int k = 0; k < 4; k++) begin
        mq[k].delete();
        zero_since_rst[k] = 1'b1;
      end
      m_known = 1'b1;
    end else if (m_known) begin
      for (int k = 0; k < 4; k++)
        if (mq[k].size() != 0 && ordy[k]) void'(mq[k].pop_front());
      if (v && rdy) begin
        mq[s].push_back(d);
        zero_since_rst[s] = 1'b0;
        last_acc = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = '0;
    out_ready = 4'hF;
    reset_n   = 1'b0;
    @(negedge clk);

    // Reset held two cycles with a valid input: nothing may load.
    cycle(1'b1, 2'd0, 32'hFFFF_FFFF, 4'hF, 1'b0);
    cycle(1'b1, 2'd1, 32'h1234_5678, 4'hF, 1'b0);
    chk("rst_out_valid", 128'(out_valid), 128'(4'b0000));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));

    // Single route to lane c.
    cycle(1'b1, 2'd2, 32'hDEAD_BEEF, 4'hF, 1'b1);
    chk("route_valid", 128'(out_valid), 128'(4'b0100));
    chk("route_lane_c", 128'(out_data[2*W +: W]), 128'(32'hDEAD_BEEF));
    chk("route_lane_abd", 128'({out_data[3*W +: W], out_data[1*W +: W], out_data[0 +: W]}), 128'(0));
    cycle(1'b0, 2'd0, '0, 4'hF, 1'b1);
    chk("route_drained", 128'(out_valid), 128'(4'b0000));

    // Backpressure on lane b, then pass-through refill.
    cycle(1'b1, 2'd1, 32'h1, 4'b1101, 1'b1);
    cycle(1'b1, 2'd1, 32'h2, 4'b1101, 1'b1);
    chk("bp_not_accepted", 128'(last_acc), 128'(0));
    chk("bp_in_ready", 128'(in_ready), 128'(0));
    cycle(1'b1, 2'd1, 32'h2, 4'b1101, 1'b1);
    chk("bp_hold", 128'(out_data[1*W +: W]), 128'(32'h1));
    cycle(1'b1, 2'd1, 32'h2, 4'b1111, 1'b1);
    chk("bp_refill_acc", 128'(last_acc), 128'(1));
    chk("bp_refill_valid", 128'(out_valid), 128'(4'b0010));
    chk("bp_refill_data", 128'(out_data[1*W +: W]), 128'(32'h2));
    cycle(1'b0, 2'd0, '0, 4'hF, 1'b1);

    // Lane isolation: lane a stalled, lane d still accepts.
    cycle(1'b1, 2'd0, 32'h7, 4'b1110, 1'b1);
    cycle(1'b1, 2'd3, 32'hA5, 4'b1110, 1'b1);
    chk("iso_acc", 128'(last_acc), 128'(1));
    chk("iso_valid", 128'(out_valid), 128'(4'b1001));
    chk("iso_lane_d", 128'(out_data[3*W +: W]), 128'(32'hA5));
    cycle(1'b0, 2'd0, '0, 4'hF, 1'b1);

    // Streaming into lane a at full rate.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 2'd0, W'(i), 4'hF, 1'b1);
      chk("stream_acc", 128'(last_acc), 128'(1));
      chk("stream_data", 128'(out_data[0 +: W]), 128'(i));
      chk("stream_valid", 128'(out_valid), 128'(4'b0001));
    end
    cycle(1'b0, 2'd0, '0, 4'hF, 1'b1);

    // Reset mid-operation discards a stalled word.
    cycle(1'b1, 2'd2, 32'hCAFE_0001, 4'b0000, 1'b1);
    cycle(1'b1, 2'd3, 32'hCAFE_0002, 4'b0000, 1'b0);
    chk("midrst_valid", 128'(out_valid), 128'(4'b0000));
    chk("midrst_data", 128'(out_data), 128'(0));

    // Random traffic with occasional resets; the model checks every cycle.
    for (int n = 0; n < 10000; n++) begin
      logic [3:0] r;
      r[0] = ($urandom_range(0, 3) != 0);
      r[1] = ($urandom_range(0, 3) != 0);
      r[2] = ($urandom_range(0, 1) != 0);
      r[3] = ($urandom_range(0, 7) != 0);
      cycle(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), W'($urandom),
            r, ($urandom_range(0, 999) != 0));
    end
    cycle(1'b0, 2'd0, '0, 4'hF, 1'b1);
    cycle(1'b0, 2'd0, '0, 4'hF, 1'b1);
    chk("final_empty", 128'(out_valid), 128'(4'b0000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_demux4way_buf
